// File: rtl/game_ctrl.sv
// Breakout game sequencer: state machine, frame tick, lives, score and brick alive mask.
// Latency: a brick kill lands one cycle after its frame_tick cycle; state and outputs change on the edge after the qualifying inputs.
// Backpressure: none. hit_req is only looked at on frame_tick cycles in PLAY; at most one brick dies per frame.
// Ports: clock/reset (sync, active-high); start, ball_lost, hit_req[N] in;
//        alive[N], kill[N], frame_tick, ball_run, ball_reset, score[7], lives[2], state[3] out.
module game_ctrl #(
  parameter int N_BLOCKS     = 10,
  parameter int LIVES        = 3,
  parameter int TICK_DIV     = 416667,
  parameter int SERVE_FRAMES = 60
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic                ball_lost,
  input  logic [N_BLOCKS-1:0] hit_req,
  output logic [N_BLOCKS-1:0] alive,
  output logic [N_BLOCKS-1:0] kill,
  output logic                frame_tick,
  output logic                ball_run,
  output logic                ball_reset,
  output logic [6:0]          score,
  output logic [1:0]          lives,
  output logic [2:0]          state
);

  localparam int CNT_W = $clog2(TICK_DIV);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SERVE = 3'd1,
    S_PLAY  = 3'd2,
    S_WIN   = 3'd3,
    S_OVER  = 3'd4
  } state_t;

  state_t              state_q;
  state_t              state_d;
  logic [CNT_W-1:0]    frame_cnt;
  logic [7:0]          serve_cnt;

  logic                tick_play;
  logic [N_BLOCKS-1:0] elig;
  logic [N_BLOCKS-1:0] win_bit;
  logic [N_BLOCKS-1:0] alive_after;
  logic                won;
  logic                lost;
  logic                new_game;
  logic                serve_last;

  // Arbitration and event qualification shared by the FSM and the datapath.
  always_comb begin
    tick_play   = frame_tick && (state_q == S_PLAY);
    elig        = tick_play ? (hit_req & alive) : '0;
    // Isolate the lowest set bit: the lowest-index eligible brick wins.
    win_bit     = elig & (~elig + N_BLOCKS'(1));
    alive_after = alive & ~win_bit;
    // Clearing the final brick wins the game, even if the ball is lost in the same cycle.
    won         = (|win_bit) && (alive_after == '0);
    lost        = (state_q == S_PLAY) && ball_lost && !won;
    new_game    = (state_q == S_IDLE) && start;
    serve_last  = frame_tick && (serve_cnt == 8'(SERVE_FRAMES - 1));
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_SERVE;
      S_SERVE: if (serve_last) state_d = S_PLAY;
      S_PLAY: begin
        if (won)       state_d = S_WIN;
        else if (lost) state_d = (lives == 2'd1) ? S_OVER : S_SERVE;
      end
      S_WIN, S_OVER: if (!start) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from the state register, so they switch with the state.
  always_comb begin
    ball_run   = (state_q == S_PLAY);
    ball_reset = (state_q == S_IDLE) || (state_q == S_SERVE);
    state      = state_q;
  end

  // Frame counter runs in every state.
  always_ff @(posedge clock) begin
    if (reset) begin
      frame_cnt  <= '0;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= (frame_cnt == CNT_W'(TICK_DIV - 1));
      if (frame_cnt == CNT_W'(TICK_DIV - 1)) frame_cnt <= '0;
      else                                   frame_cnt <= frame_cnt + CNT_W'(1);
    end
  end

  // Game datapath: alive mask, kill pulse, score, lives, serve counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      alive     <= '1;
      kill      <= '0;
      score     <= 7'd0;
      lives     <= 2'(LIVES);
      serve_cnt <= 8'd0;
    end else begin
      // win_bit is zero outside PLAY tick cycles, so kill is a single-cycle pulse.
      kill <= win_bit;

      if (new_game) alive <= '1;
      else          alive <= alive_after;

      if (new_game)                          score <= 7'd0;
      else if ((|win_bit) && score != 7'd99) score <= score + 7'd1;

      if (new_game)  lives <= 2'(LIVES);
      else if (lost) lives <= lives - 2'd1;

      // Restart serve timing on every entry into SERVE.
      if (new_game || (lost && lives != 2'd1))
        serve_cnt <= 8'd0;
      else if (state_q == S_SERVE && frame_tick && !serve_last)
        serve_cnt <= serve_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_game_ctrl.sv
module tb_game_ctrl;
  localparam int N  = 10;
  localparam int TD = 4;
  localparam int SF = 2;
  localparam int LV = 3;

  logic         clock = 1'b0;
  logic         reset;
  logic         start;
  logic         ball_lost;
  logic [N-1:0] hit_req;
  logic [N-1:0] alive;
  logic [N-1:0] kill;
  logic         frame_tick;
  logic         ball_run;
  logic         ball_reset;
  logic [6:0]   score;
  logic [1:0]   lives;
  logic [2:0]   state;

  always #5 clock = ~clock;

  game_ctrl #(
    .N_BLOCKS(N), .LIVES(LV), .TICK_DIV(TD), .SERVE_FRAMES(SF)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .ball_lost(ball_lost),
    .hit_req(hit_req), .alive(alive), .kill(kill), .frame_tick(frame_tick),
    .ball_run(ball_run), .ball_reset(ball_reset), .score(score),
    .lives(lives), .state(state)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: game described as numbers and a brick bitmap.
  // k counts clock edges since the reset edge; a frame tick is visible whenever k is a nonzero multiple of TD.
  int           k;
  int           m_state;   // 0 idle, 1 serve, 2 play, 3 win, 4 over
  int           m_score;
  int           m_lives;
  int           m_frames;  // frames already spent serving
  logic [N-1:0] m_alive;
  logic [N-1:0] m_kill;
  bit           m_tick;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h at k=%0d", tag, obs, exp, k);
    end
  endtask

  task automatic check_all();
    chk("state", 32'(state), 32'(m_state));
    chk("alive", 32'(alive), 32'(m_alive));
    chk("kill", 32'(kill), 32'(m_kill));
    chk("frame_tick", 32'(frame_tick), 32'(m_tick));
    chk("ball_run", 32'(ball_run), 32'(m_state == 2));
    chk("ball_reset", 32'(ball_reset), 32'(m_state <= 1));
    chk("score", 32'(score), 32'(m_score));
    chk("lives", 32'(lives), 32'(m_lives));
  endtask

  task automatic model_reset();
    k = 0; m_tick = 0; m_state = 0; m_score = 0; m_lives = LV;
    m_frames = 0; m_alive = '1; m_kill = '0;
  endtask

  // Advance the model across one clock edge given the inputs seen before it.
  task automatic model_edge(input bit st, input bit bl, input logic [N-1:0] hr);
    bit           tick_now;
    int           win;
    logic [N-1:0] nk;
    tick_now = m_tick;
    win = -1;
    nk = '0;
    k++;
    m_tick = (k % TD == 0);
    case (m_state)
      0: if (st) begin
        m_state = 1; m_alive = '1; m_score = 0; m_lives = LV; m_frames = 0;
      end
      1: if (tick_now) begin
        if (m_frames + 1 == SF) m_state = 2;
        else m_frames++;
      end
      2: begin
        if (tick_now)
          for (int i = N - 1; i >= 0; i--) if (hr[i] && m_alive[i]) win = i;
        if (win >= 0) begin
          m_alive[win] = 1'b0;
          nk[win] = 1'b1;
          if (m_score < 99) m_score++;
        end
        if (win >= 0 && m_alive == '0) m_state = 3;
        else if (bl) begin
          m_lives--;
          if (m_lives == 0) m_state = 4;
          else begin m_state = 1; m_frames = 0; end
        end
      end
      default: if (!st) m_state = 0;
    endcase
    m_kill = nk;
  endtask

  task automatic cyc(input bit st, input bit bl, input logic [N-1:0] hr);
    start = st; ball_lost = bl; hit_req = hr;
    @(posedge clock);
    model_edge(st, bl, hr);
    #1;
    check_all();
  endtask

  task automatic do_reset(input logic [N-1:0] hr);
    reset = 1'b1; start = 1'b0; ball_lost = 1'b0; hit_req = hr;
    @(posedge clock);
    model_reset();
    #1;
    check_all();
    reset = 1'b0;
  endtask

  task automatic wait_play();
    int n;
    n = 0;
    while (m_state != 2 && n < 40) begin
      cyc(1'b1, 1'b0, '0);
      n++;
    end
    chk("reach_play", 32'(state), 32'd2);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] ks[$];
    int           n;
    bit           bl;

    reset = 1'b1; start = 1'b0; ball_lost = 1'b0; hit_req = '0;
    do_reset('0);

    // Start, serve for two frames, enter PLAY.
    cyc(1'b1, 1'b0, '0);
    chk("serve_after_start", 32'(state), 32'd1);
    wait_play();

    // Two bricks requested across two ticks: lowest first, one per tick.
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 1'b0, 10'b0000101000);
      if (kill != '0) ks.push_back(kill);
    end
    chk("kill_count", 32'(ks.size()), 32'd2);
    if (ks.size() >= 2) begin
      chk("kill_first", 32'(ks[0]), 32'h008);
      chk("kill_second", 32'(ks[1]), 32'h020);
    end
    chk("score_two", 32'(score), 32'd2);
    chk("alive_3d7", 32'(alive), 32'h3D7);

    // Three single-cycle losses: serve, serve, over.
    for (int i = 0; i < 3; i++) begin
      wait_play();
      cyc(1'b1, 1'b1, '0);
    end
    chk("over_state", 32'(state), 32'd4);
    chk("over_lives", 32'(lives), 32'd0);
    cyc(1'b0, 1'b0, '0);
    chk("idle_after_over", 32'(state), 32'd0);

    // A held ball_lost costs one life only.
    cyc(1'b1, 1'b0, '0);
    wait_play();
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, '0);
    chk("held_lost_lives", 32'(lives), 32'd2);

    // Clear every brick; the last kill coincides with ball_lost.
    do_reset('0);
    cyc(1'b1, 1'b0, '0);
    wait_play();
    n = 0;
    while (m_state == 2 && n < 200) begin
      bl = m_tick && ($countones(m_alive) == 1);
      cyc(1'b1, bl, '1);
      n++;
    end
    chk("win_state", 32'(state), 32'd3);
    chk("win_lives", 32'(lives), 32'd3);
    chk("win_score", 32'(score), 32'd10);
    chk("win_alive", 32'(alive), 32'h000);
    cyc(1'b0, 1'b0, '0);
    chk("idle_after_win", 32'(state), 32'd0);

    // A request on a dead brick alone does nothing.
    do_reset('0);
    cyc(1'b1, 1'b0, '0);
    wait_play();
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 10'b1);
    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 10'b1);
    chk("dead_score", 32'(score), 32'd1);
    chk("dead_alive", 32'(alive), 32'h3FE);

    // Reset on a tick cycle with a kill pending.
    n = 0;
    while (!m_tick && n < 10) begin
      cyc(1'b1, 1'b0, '1);
      n++;
    end
    chk("pending_tick", 32'(frame_tick), 32'd1);
    do_reset('1);
    chk("rst_kill", 32'(kill), 32'd0);
    chk("rst_alive", 32'(alive), 32'h3FF);
    chk("rst_score", 32'(score), 32'd0);
    chk("rst_lives", 32'(lives), 32'd3);
    chk("rst_state", 32'(state), 32'd0);

    // Randomized play against the model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0)
        do_reset(N'($urandom));
      else
        cyc($urandom_range(0, 9) != 0, $urandom_range(0, 29) == 0,
            N'($urandom) & N'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
